alu_cmd_sequencer: RTL and testbench

- Initiator-side controller for the 8-bit ALU (A, B, FunSel in; OutALU, ZCNO out).
- Accepts operation commands over a valid/ready interface and drives the ALU operands and FunSel.
- Waits the ALU's registered latency, captures result and flags, and returns them over a valid/ready response interface.
- Also executes 16-bit wide adds as two chained 8-bit ALU operations using the ALU's carry.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_lat_counter.sv | 40 ++++
 rtl/alu_cmd_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

  // Sequencer states: wait for a command, low byte, high byte, hold response.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC_LO = 2'd1,
    EXEC_HI = 2'd2,
    RESP    = 2'd3
  } seq_state_e;

  // Bit positions inside the 4-bit {Z,C,N,O} flag vector.
  localparam int ZCNO_Z = 3;
  localparam int ZCNO_C = 2;
  localparam int ZCNO_N = 1;
  localparam int ZCNO_O = 0;

  // FunSel codes used for the chained 16-bit add.
  localparam logic [3:0] FS_ADD_DEFAULT  = 4'h4;
  localparam logic [3:0] FS_ADDC_DEFAULT = 4'h5;

  // Width of the latency counter; covers latencies 1..7.
  localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/alu_lat_counter.sv
// Down-counter that marks the last clock edge of an ALU latency window.
// Loading at edge N makes done high during the cycle that ends at edge
// N+load_val, so the owner samples the ALU on exactly that edge.
module alu_lat_counter
  import alu_seq_pkg::*;
#(
  parameter int W = LAT_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load takes priority so a second phase can restart on the edge the first ends.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator-side sequencer for an 8-bit ALU: takes commands over valid/ready,
// drives ALU operands, waits the ALU latency, and returns result and flags.
// Wide commands run as an 8-bit add followed by an add-with-carry.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         ALU_LATENCY = 1,
  parameter logic [3:0] FS_ADD      = FS_ADD_DEFAULT,
  parameter logic [3:0] FS_ADDC     = FS_ADDC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WIDE,
  input  logic [3:0]  CMD_FUNSEL,
  input  logic [15:0] CMD_A,
  input  logic [15:0] CMD_B,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [15:0] RSP_DATA,
  output logic [3:0]  RSP_ZCNO,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic [3:0]  ALU_FUNSEL,
  input  logic [7:0]  ALU_OUT,
  input  logic [3:0]  ALU_ZCNO
);

  seq_state_e  state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [3:0]  rsp_zcno_q, rsp_zcno_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [3:0]  alu_funsel_q, alu_funsel_d;
  logic [7:0]  a_hi_q, a_hi_d;
  logic [7:0]  b_hi_q, b_hi_d;
  logic        wide_q, wide_d;
  logic [7:0]  lo_q, lo_d;
  logic        z_lo_q, z_lo_d;
  logic        cnt_load;
  logic        cnt_done;

  // One counter serves both phases; it is reloaded on each ALU issue.
  alu_lat_counter #(
    .W (LAT_CNT_W)
  ) u_lat_counter (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (cnt_load),
    .load_val (LAT_CNT_W'(ALU_LATENCY)),
    .done     (cnt_done)
  );

  // Next-state, ALU drive and response capture; everything holds by default.
  always_comb begin
    state_d      = state_q;
    rsp_data_d   = rsp_data_q;
    rsp_zcno_d   = rsp_zcno_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_funsel_d = alu_funsel_q;
    a_hi_d       = a_hi_q;
    b_hi_d       = b_hi_q;
    wide_d       = wide_q;
    lo_d         = lo_q;
    z_lo_d       = z_lo_q;
    cnt_load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          a_hi_d       = CMD_A[15:8];
          b_hi_d       = CMD_B[15:8];
          wide_d       = CMD_WIDE;
          alu_a_d      = CMD_A[7:0];
          alu_b_d      = CMD_B[7:0];
          alu_funsel_d = CMD_WIDE ? FS_ADD : CMD_FUNSEL;
          cnt_load     = 1'b1;
          state_d      = EXEC_LO;
        end
      end

      EXEC_LO: begin
        if (cnt_done) begin
          lo_d   = ALU_OUT;
          z_lo_d = ALU_ZCNO[ZCNO_Z];
          if (wide_q) begin
            // High byte issues on the same edge the low result is taken.
            alu_a_d      = a_hi_q;
            alu_b_d      = b_hi_q;
            alu_funsel_d = FS_ADDC;
            cnt_load     = 1'b1;
            state_d      = EXEC_HI;
          end else begin
            rsp_data_d = {8'h00, ALU_OUT};
            rsp_zcno_d = ALU_ZCNO;
            state_d    = RESP;
          end
        end
      end

      EXEC_HI: begin
        if (cnt_done) begin
          rsp_data_d = {ALU_OUT, lo_q};
          // Zero only if both halves are zero; C/N/O come from the top byte.
          rsp_zcno_d = {z_lo_q & ALU_ZCNO[ZCNO_Z], ALU_ZCNO[ZCNO_C],
                        ALU_ZCNO[ZCNO_N], ALU_ZCNO[ZCNO_O]};
          state_d    = RESP;
        end
      end

      RESP: begin
        if (RSP_READY) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered copies of the next state.
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zcno_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_funsel_q <= '0;
      a_hi_q       <= '0;
      b_hi_q       <= '0;
      wide_q       <= 1'b0;
      lo_q         <= '0;
      z_lo_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zcno_q   <= rsp_zcno_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_funsel_q <= alu_funsel_d;
      a_hi_q       <= a_hi_d;
      b_hi_q       <= b_hi_d;
      wide_q       <= wide_d;
      lo_q         <= lo_d;
      z_lo_q       <= z_lo_d;
    end
  end

  assign CMD_READY  = cmd_ready_q;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_DATA   = rsp_data_q;
  assign RSP_ZCNO   = rsp_zcno_q;
  assign ALU_A      = alu_a_q;
  assign ALU_B      = alu_b_q;
  assign ALU_FUNSEL = alu_funsel_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural 8-bit ALU
// (result visible one edge after issue, carry flag kept in a register).
module tb_alu_cmd_sequencer;

  localparam int LAT = 1;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WIDE = 1'b0;
  logic [3:0]  CMD_FUNSEL = 4'h0;
  logic [15:0] CMD_A = 16'h0;
  logic [15:0] CMD_B = 16'h0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [15:0] RSP_DATA;
  logic [3:0]  RSP_ZCNO;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUNSEL;
  logic [7:0]  ALU_OUT;
  logic [3:0]  ALU_ZCNO;

  int asserts = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_cmd_sequencer #(
    .ALU_LATENCY (LAT)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_WIDE   (CMD_WIDE),
    .CMD_FUNSEL (CMD_FUNSEL),
    .CMD_A      (CMD_A),
    .CMD_B      (CMD_B),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_DATA   (RSP_DATA),
    .RSP_ZCNO   (RSP_ZCNO),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_FUNSEL (ALU_FUNSEL),
    .ALU_OUT    (ALU_OUT),
    .ALU_ZCNO   (ALU_ZCNO)
  );

  // ---------------- behavioural ALU ----------------
  // 0: pass A, 4: add, 5: add with stored carry, 6: A-B, 7: A&B.
  logic       c_store;
  logic [8:0] alu_s;
  logic       alu_c;
  logic       alu_o;

  always_comb begin
    alu_s = 9'd0;
    alu_c = 1'b0;
    alu_o = 1'b0;
    case (ALU_FUNSEL)
      4'h4: begin
        alu_s = {1'b0, ALU_A} + {1'b0, ALU_B};
        alu_c = alu_s[8];
        alu_o = (ALU_A[7] == ALU_B[7]) && (alu_s[7] != ALU_A[7]);
      end
      4'h5: begin
        alu_s = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, c_store};
        alu_c = alu_s[8];
        alu_o = (ALU_A[7] == ALU_B[7]) && (alu_s[7] != ALU_A[7]);
      end
      4'h6: begin
        alu_s = {1'b0, ALU_A} + {1'b0, ~ALU_B} + 9'd1;
        alu_c = alu_s[8];
        alu_o = (ALU_A[7] != ALU_B[7]) && (alu_s[7] != ALU_A[7]);
      end
      4'h7:    alu_s = {1'b0, ALU_A & ALU_B};
      default: alu_s = {1'b0, ALU_A};
    endcase
  end

  assign ALU_OUT  = alu_s[7:0];
  assign ALU_ZCNO = {(alu_s[7:0] == 8'h00), alu_c, alu_s[7], alu_o};

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) c_store <= 1'b0;
    else if (ALU_FUNSEL == 4'h4 || ALU_FUNSEL == 4'h5) c_store <= alu_c;
  end

  // ---------------- reference model ----------------
  // Returns {ZCNO, DATA} of a single 8-bit op, from integer arithmetic.
  function automatic logic [19:0] exp_single(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, r, sr;
    logic c, o;
    logic [7:0] res;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; o = 1'b0; r = ua;
    case (fs)
      4'h4: begin r = ua + ub; c = (r > 255); sr = sa + sb; o = (sr > 127) || (sr < -128); end
      4'h6: begin r = ua - ub; c = (ua >= ub); sr = sa - sb; o = (sr > 127) || (sr < -128); end
      4'h7: r = ua & ub;
      default: r = ua;
    endcase
    res = 8'(r);
    return {(res == 8'h00), c, res[7], o, 8'h00, res};
  endfunction

  // Returns {ZCNO, DATA} of a 16-bit add.
  function automatic logic [19:0] exp_wide(input logic [15:0] a, input logic [15:0] b);
    int sum, ssum;
    logic [15:0] res;
    sum  = int'(a) + int'(b);
    ssum = int'($signed(a)) + int'($signed(b));
    res  = 16'(sum);
    return {(res == 16'h0000), (sum > 65535), res[15], (ssum > 32767) || (ssum < -32768), res};
  endfunction

  // ---------------- transaction driver/checker ----------------
  task automatic run_cmd(input logic wide, input logic [3:0] fs, input logic [15:0] a,
                         input logic [15:0] b, input logic [19:0] e, input int hold,
                         input logic keep_valid);
    int n, lat, exp_lat;
    logic [15:0] d0;
    logic [3:0] z0;
    logic [3:0] fs_lo;
    exp_lat = wide ? 2 * LAT : LAT;
    fs_lo = wide ? 4'h4 : fs;
    CMD_VALID = 1'b1; CMD_WIDE = wide; CMD_FUNSEL = fs; CMD_A = a; CMD_B = b;
    n = 0;
    while (CMD_READY !== 1'b1 && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    asserts++;
    if (CMD_READY !== 1'b1)
      begin failures++; $display("FAIL accept_timeout: CMD_READY=%b required 1", CMD_READY); end
    @(posedge CLK); #1;
    // Scramble the command bus; none of it may be taken until the next accept.
    CMD_VALID = keep_valid; CMD_WIDE = 1'($urandom); CMD_FUNSEL = 4'($urandom);
    CMD_A = 16'($urandom); CMD_B = 16'($urandom);
    asserts++;
    if (ALU_FUNSEL !== fs_lo || ALU_A !== a[7:0] || ALU_B !== b[7:0]) begin
      failures++;
      $display("FAIL alu_issue_lo: fs=%h a=%h b=%h required fs=%h a=%h b=%h",
               ALU_FUNSEL, ALU_A, ALU_B, fs_lo, a[7:0], b[7:0]);
    end
    asserts++;
    if (CMD_READY !== 1'b0)
      begin failures++; $display("FAIL busy_ready: CMD_READY=%b required 0", CMD_READY); end
    lat = 0;
    while (RSP_VALID !== 1'b1 && lat < 20) begin
      @(posedge CLK); #1; lat++;
      if (wide && lat == LAT) begin
        asserts++;
        if (ALU_FUNSEL !== 4'h5 || ALU_A !== a[15:8] || ALU_B !== b[15:8]) begin
          failures++;
          $display("FAIL alu_issue_hi: fs=%h a=%h b=%h required fs=5 a=%h b=%h",
                   ALU_FUNSEL, ALU_A, ALU_B, a[15:8], b[15:8]);
        end
      end
    end
    asserts++;
    if (lat != exp_lat)
      begin failures++; $display("FAIL rsp_latency: %0d cycles required %0d", lat + 1, exp_lat + 1); end
    asserts++;
    if ({RSP_ZCNO, RSP_DATA} !== e) begin
      failures++;
      $display("FAIL rsp_value: data=%h zcno=%b required data=%h zcno=%b", RSP_DATA, RSP_ZCNO, e[15:0], e[19:16]);
    end
    d0 = RSP_DATA; z0 = RSP_ZCNO;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      asserts++;
      if (RSP_VALID !== 1'b1 || RSP_DATA !== d0 || RSP_ZCNO !== z0 || CMD_READY !== 1'b0) begin
        failures++;
        $display("FAIL rsp_hold: valid=%b data=%h zcno=%b ready=%b required valid=1 data=%h zcno=%b ready=0",
                 RSP_VALID, RSP_DATA, RSP_ZCNO, CMD_READY, d0, z0);
      end
    end
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    asserts++;
    if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
      failures++;
      $display("FAIL rsp_release: valid=%b ready=%b required valid=0 ready=1", RSP_VALID, CMD_READY);
    end
    $display("txn wide=%0b fs=%h a=%h b=%h -> data=%h zcno=%b latency=%0d",
             wide, fs, a, b, d0, z0, lat + 1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    asserts++;
    if (CMD_READY !== 1'b0 || RSP_VALID !== 1'b0 || RSP_DATA !== 16'h0 || RSP_ZCNO !== 4'h0 ||
        ALU_A !== 8'h0 || ALU_B !== 8'h0 || ALU_FUNSEL !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h zcno=%b a=%h b=%h fs=%h required all 0",
               CMD_READY, RSP_VALID, RSP_DATA, RSP_ZCNO, ALU_A, ALU_B, ALU_FUNSEL);
    end
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    asserts++;
    if (CMD_READY !== 1'b1 || RSP_VALID !== 1'b0)
      begin failures++; $display("FAIL reset_release: ready=%b valid=%b required ready=1 valid=0", CMD_READY, RSP_VALID); end
  endtask

  task automatic test_single();
    run_cmd(1'b0, 4'h4, 16'h0005, 16'h0002, {4'b0000, 16'h0007}, 0, 1'b0);
    run_cmd(1'b0, 4'h4, 16'hAB7F, 16'hCD01, {4'b0011, 16'h0080}, 1, 1'b0);
  endtask

  task automatic test_wide();
    run_cmd(1'b1, 4'h0, 16'h00FF, 16'h0001, {4'b0000, 16'h0100}, 0, 1'b0);
    run_cmd(1'b1, 4'h9, 16'hFFFF, 16'h0001, {4'b1100, 16'h0000}, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Command stays valid through a 5-cycle stall; next one goes only after IDLE.
    run_cmd(1'b0, 4'h7, 16'h003C, 16'h000F, {4'b0000, 16'h000C}, 5, 1'b1);
    run_cmd(1'b1, 4'h0, 16'h1234, 16'h0FFF, {4'b0000, 16'h2233}, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] fs_tab [4];
    logic w;
    logic [3:0] fs;
    logic [15:0] a, b;
    fs_tab[0] = 4'h0; fs_tab[1] = 4'h4; fs_tab[2] = 4'h6; fs_tab[3] = 4'h7;
    for (int t = 0; t < 40; t++) begin
      w  = 1'($urandom_range(0, 1));
      fs = fs_tab[$urandom_range(0, 3)];
      a  = 16'($urandom);
      b  = 16'($urandom);
      run_cmd(w, fs, a, b, w ? exp_wide(a, b) : exp_single(fs, a[7:0], b[7:0]),
              int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    CMD_VALID = 1'b1; CMD_WIDE = 1'b1; CMD_FUNSEL = 4'h0; CMD_A = 16'h1234; CMD_B = 16'h5678;
    @(posedge CLK); #1;          // accept edge
    CMD_VALID = 1'b0;
    repeat (LAT) @(posedge CLK); // low result taken, high byte issued
    #1;
    asserts++;
    if (ALU_A !== 8'h12 || ALU_FUNSEL !== 4'h5)
      begin failures++; $display("FAIL midop_hi_phase: a=%h fs=%h required a=12 fs=5", ALU_A, ALU_FUNSEL); end
    RESET_N = 1'b0;
    #1;
    asserts++;
    if (CMD_READY !== 1'b0 || RSP_VALID !== 1'b0 || RSP_DATA !== 16'h0 || RSP_ZCNO !== 4'h0 ||
        ALU_A !== 8'h0 || ALU_B !== 8'h0 || ALU_FUNSEL !== 4'h0) begin
      failures++;
      $display("FAIL midop_async_reset: ready=%b valid=%b data=%h zcno=%b a=%h b=%h fs=%h required all 0",
               CMD_READY, RSP_VALID, RSP_DATA, RSP_ZCNO, ALU_A, ALU_B, ALU_FUNSEL);
    end
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    asserts++;
    if (CMD_READY !== 1'b1)
      begin failures++; $display("FAIL midop_ready_after: CMD_READY=%b required 1", CMD_READY); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (RSP_VALID !== 1'b0) seen++;
      @(posedge CLK); #1;
    end
    asserts++;
    if (seen != 0)
      begin failures++; $display("FAIL midop_no_response: RSP_VALID high %0d cycles required 0", seen); end
    $display("txn reset during EXEC_HI -> abandoned");
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_wide();
    test_back_to_back();
    test_random();
    test_reset_midop();
    run_cmd(1'b0, 4'h6, 16'h0010, 16'h0020, exp_single(4'h6, 8'h10, 8'h20), 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
